// File: rtl/filtroup_pkg.sv
// Shared constants, state encoding and small helpers for the filtroup line sequencer.
package filtroup_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int TAPS           = 7;
    localparam int CENTRE         = 3;
    localparam int FLUSH_LEN      = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IN     = 3'd1;
    localparam logic [2:0] ST_FLUSH  = 3'd2;
    localparam logic [2:0] ST_EMIT_A = 3'd3;
    localparam logic [2:0] ST_EMIT_B = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        IN     = ST_IN,
        FLUSH  = ST_FLUSH,
        EMIT_A = ST_EMIT_A,
        EMIT_B = ST_EMIT_B
    } state_e;

    // Shifts since line load; saturates once the centre tap holds a real pixel.
    function automatic logic [1:0] pcnt_inc(input logic [1:0] pcnt);
        return (pcnt == 2'(CENTRE)) ? pcnt : pcnt + 2'd1;
    endfunction

endpackage

// File: rtl/filtroup_ctrl_if.sv
// Valid/ready pixel stream used on both sides of the line sequencer.
interface filtroup_ctrl_if
    import filtroup_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
) ();

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);

endinterface

// File: rtl/filtroup_clip.sv
// Saturates a signed filter result (two guard bits) to an unsigned pixel.
module filtroup_clip
    import filtroup_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
)
(
    input  logic signed [DW+1:0] i_val,
    output logic        [DW-1:0] o_clip
);

    // Top bit set means negative; otherwise bit DW set means above full scale.
    always_comb begin
        if (i_val[DW+1])    o_clip = '0;
        else if (i_val[DW]) o_clip = '1;
        else                o_clip = i_val[DW-1:0];
    end

endmodule

// File: rtl/filtroup_ctrl.sv
// x2 upsampler line sequencer: keeps a 7-tap sliding window for filtroup and
// emits the centre pixel followed by the clipped half-pixel result per input pixel.
module filtroup_ctrl
    import filtroup_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    filtroup_ctrl_if.slave               s,
    filtroup_ctrl_if.master              m,
    output logic signed [DATA_WIDTH+1:0] filt_in0,
    output logic signed [DATA_WIDTH+1:0] filt_in1,
    output logic signed [DATA_WIDTH+1:0] filt_in2,
    output logic signed [DATA_WIDTH+1:0] filt_in3,
    output logic signed [DATA_WIDTH+1:0] filt_in4,
    output logic signed [DATA_WIDTH+1:0] filt_in5,
    output logic signed [DATA_WIDTH+1:0] filt_in6,
    input  logic signed [DATA_WIDTH+1:0] filt_out,
    output logic                         busy
);

    localparam int TW = DATA_WIDTH + 2;
    typedef logic signed [TW-1:0] tap_t;

    tap_t                  r_win     [TAPS];
    tap_t                  w_win_nxt [TAPS];
    tap_t                  w_ext;
    tap_t                  w_src;
    logic [2:0]            r_state, w_state_nxt;
    logic [1:0]            r_pcnt, w_pcnt_nxt;
    logic [1:0]            r_fcnt, w_fcnt_nxt;
    logic                  r_eol, w_eol_nxt;
    logic                  w_load, w_shift;
    logic                  r_s_ready, r_m_valid, r_m_last;
    logic [DATA_WIDTH-1:0] r_m_data, w_clip;
    logic                  w_s_acc, w_m_acc, w_emit_enter, w_emit_last;

    assign w_s_acc      = s.valid && r_s_ready;
    assign w_m_acc      = r_m_valid && m.ready;
    assign w_ext        = {2'b00, s.data};
    assign w_emit_enter = (w_state_nxt == ST_EMIT_A) && (r_state != ST_EMIT_A);
    assign w_emit_last  = r_eol && (r_fcnt == 2'd0);

    filtroup_clip #(.DW(DATA_WIDTH)) u_clip (
        .i_val  (filt_out),
        .o_clip (w_clip)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_fcnt_nxt  = r_fcnt;
        w_eol_nxt   = r_eol;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_src       = r_win[TAPS-1];
        case (r_state)
            ST_IDLE: begin
                if (w_s_acc) begin
                    w_load     = 1'b1;
                    w_pcnt_nxt = 2'd0;
                    if (s.last) begin
                        w_fcnt_nxt  = 2'(FLUSH_LEN);
                        w_eol_nxt   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_IN;
                    end
                end
            end
            ST_IN: begin
                if (w_s_acc) begin
                    w_shift    = 1'b1;
                    w_src      = w_ext;
                    w_pcnt_nxt = pcnt_inc(r_pcnt);
                    if (s.last) begin
                        w_fcnt_nxt = 2'(FLUSH_LEN);
                        w_eol_nxt  = 1'b1;
                    end
                    if (w_pcnt_nxt == 2'(CENTRE)) w_state_nxt = ST_EMIT_A;
                    else if (s.last)              w_state_nxt = ST_FLUSH;
                    else                          w_state_nxt = ST_IN;
                end
            end
            ST_FLUSH: begin
                // Right-edge replicate: the newest tap is shifted in again.
                w_shift     = 1'b1;
                w_fcnt_nxt  = r_fcnt - 2'd1;
                w_pcnt_nxt  = pcnt_inc(r_pcnt);
                w_state_nxt = (w_pcnt_nxt == 2'(CENTRE)) ? ST_EMIT_A : ST_FLUSH;
            end
            ST_EMIT_A: begin
                if (w_m_acc) w_state_nxt = ST_EMIT_B;
            end
            ST_EMIT_B: begin
                if (w_m_acc) begin
                    if (r_fcnt != 2'd0) begin
                        w_state_nxt = ST_FLUSH;
                    end else if (r_eol) begin
                        w_state_nxt = ST_IDLE;
                        w_eol_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IN;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++) w_win_nxt[i] = r_win[i];
        if (w_load) begin
            // Left-edge replicate: the first pixel fills the whole window.
            for (int i = 0; i < TAPS; i++) w_win_nxt[i] = w_ext;
        end else if (w_shift) begin
            for (int i = 0; i < TAPS - 1; i++) w_win_nxt[i] = r_win[i+1];
            w_win_nxt[TAPS-1] = w_src;
        end
    end

    // NOTE: the window is a seven-entry register array rather than a RAM, so it is
    //       cleared by reset together with the FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) r_win[i] <= '0;
            r_state   <= ST_IDLE;
            r_pcnt    <= 2'd0;
            r_fcnt    <= 2'd0;
            r_eol     <= 1'b0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else begin
            // NOTE: non-blocking updates make every register here see pre-edge values.
            for (int i = 0; i < TAPS; i++) r_win[i] <= w_win_nxt[i];
            r_state   <= w_state_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_eol     <= w_eol_nxt;
            r_s_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_IN);
            if (w_emit_enter) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_win_nxt[CENTRE][DATA_WIDTH-1:0];
                r_m_last  <= 1'b0;
            end else if ((r_state == ST_EMIT_A) && w_m_acc) begin
                r_m_data  <= w_clip;
                r_m_last  <= w_emit_last;
            end else if ((r_state == ST_EMIT_B) && w_m_acc) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign s.ready  = r_s_ready;
    assign m.valid  = r_m_valid;
    assign m.data   = r_m_data;
    assign m.last   = r_m_last;
    assign busy     = (r_state != ST_IDLE);

    assign filt_in0 = r_win[0];
    assign filt_in1 = r_win[1];
    assign filt_in2 = r_win[2];
    assign filt_in3 = r_win[3];
    assign filt_in4 = r_win[4];
    assign filt_in5 = r_win[5];
    assign filt_in6 = r_win[6];

endmodule

// File: tb/tb_filtroup_ctrl.sv
// Bench for filtroup_ctrl: directed scenarios plus random lines against a line-level model.
module tb_filtroup_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    filtroup_ctrl_if #(.DW(DW)) s_if ();
    filtroup_ctrl_if #(.DW(DW)) m_if ();

    logic signed [DW+1:0] filt_in0, filt_in1, filt_in2, filt_in3, filt_in4, filt_in5, filt_in6;
    logic signed [DW+1:0] filt_out, w_stub;
    logic                 busy;
    logic                 ovr_en = 1'b0;
    int                   n_beats = 0;
    int                   n_vec = 0;
    int                   n_err = 0;

    logic [DW-1:0] tx_q  [$];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   rx_q  [$];

    wire [7*(DW+2)-1:0] taps_flat = {filt_in6, filt_in5, filt_in4, filt_in3, filt_in2, filt_in1, filt_in0};

    // Filter stub: average of the centre and next tap, or forced values for the clip test.
    assign w_stub   = (filt_in3 + filt_in4) >>> 1;
    assign filt_out = ovr_en ? ((n_beats < 2) ? -10'sd5 : 10'sd300) : w_stub;

    filtroup_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s_if),
        .m        (m_if),
        .filt_in0 (filt_in0),
        .filt_in1 (filt_in1),
        .filt_in2 (filt_in2),
        .filt_in3 (filt_in3),
        .filt_in4 (filt_in4),
        .filt_in5 (filt_in5),
        .filt_in6 (filt_in6),
        .filt_out (filt_out),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (m_if.valid && m_if.ready) begin
            rx_q.push_back({m_if.last, m_if.data});
            n_beats++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Line model: per pixel, the centre then floor((x[i]+x[i+1])/2), right edge replicated.
    function automatic void build_expected();
        int n = tx_q.size();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            int a = int'(tx_q[i]);
            int b = int'(tx_q[(i + 1 < n) ? i + 1 : n - 1]);
            exp_q.push_back({1'b0, tx_q[i]});
            exp_q.push_back({(i == n - 1), DW'((a + b) / 2)});
        end
    endfunction

    task automatic drive_line(input bit with_last, input int max_gap);
        for (int i = 0; i < tx_q.size(); i++) begin
            int guard;
            @(negedge clk);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            s_if.valid = 1'b1;
            s_if.data  = tx_q[i];
            s_if.last  = with_last && (i == tx_q.size() - 1);
            guard = 0;
            while (!s_if.ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            n_vec++;
            if (s_if.ready !== 1'b1) begin
                n_err++;
                $display("FAIL drive_ready: pixel %0d never accepted, s_ready=%b want 1", i, s_if.ready);
            end
            @(posedge clk);
            #1;
            s_if.valid = 1'b0;
            s_if.last  = 1'b0;
        end
    endtask

    task automatic wait_beats(input int n, input string tag);
        int guard = 0;
        while (rx_q.size() < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (rx_q.size() != n) begin
            n_err++;
            $display("FAIL %s_count: got %0d beats, want %0d", tag, rx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({m_if.valid, m_if.last, s_if.ready, busy, m_if.data, taps_flat} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: m_valid=%b m_last=%b s_ready=%b busy=%b m_data=%0d taps=%h, want all 0",
                     m_if.valid, m_if.last, s_if.ready, busy, m_if.data, taps_flat);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (s_if.ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_early: s_ready=%b want 0 before first clk", s_if.ready);
        end
        @(negedge clk);
        n_vec++;
        if (s_if.ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_rise: s_ready=%b busy=%b want 1 0", s_if.ready, busy);
        end
    endtask

    task automatic test_flat_line();
        tx_q.delete(); rx_q.delete();
        repeat (8) tx_q.push_back(8'd100);
        build_expected();
        drive_line(1'b1, 0);
        wait_beats(exp_q.size(), "flat");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL flat_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                         i, rx_q[i][DW], rx_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || s_if.ready !== 1'b1) begin
            n_err++;
            $display("FAIL flat_idle: busy=%b s_ready=%b want 0 1", busy, s_if.ready);
        end
    endtask

    task automatic test_ramp();
        tx_q = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40};
        rx_q.delete();
        build_expected();
        drive_line(1'b1, 0);
        wait_beats(exp_q.size(), "ramp");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ramp_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                         i, rx_q[i][DW], rx_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
    endtask

    task automatic test_single();
        tx_q = '{8'd77};
        rx_q.delete();
        build_expected();
        drive_line(1'b1, 0);
        wait_beats(exp_q.size(), "single");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL single_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                         i, rx_q[i][DW], rx_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || s_if.ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_idle: busy=%b s_ready=%b want 0 1", busy, s_if.ready);
        end
    endtask

    task automatic test_clip();
        tx_q = '{8'd50, 8'd60};
        rx_q.delete();
        n_beats = 0;
        ovr_en  = 1'b1;
        exp_q   = '{{1'b0, 8'd50}, {1'b0, 8'd0}, {1'b0, 8'd60}, {1'b1, 8'd255}};
        drive_line(1'b1, 0);
        wait_beats(exp_q.size(), "clip");
        ovr_en = 1'b0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL clip_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                         i, rx_q[i][DW], rx_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        tx_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        rx_q.delete();
        build_expected();
        m_if.ready = 1'b0;
        fork
            drive_line(1'b1, 0);
            begin
                int guard = 0;
                do begin
                    @(posedge clk);
                    #2;
                    guard++;
                end while (!m_if.valid && guard < 200);
                m_if.ready = 1'b1;
                @(posedge clk);
                #2;
                m_if.ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    n_vec++;
                    if (m_if.valid !== 1'b1 || m_if.data !== 8'd15 || m_if.last !== 1'b0 || s_if.ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_out: m_valid=%b m_data=%0d m_last=%b s_ready=%b, want 1 15 0 0",
                                 m_if.valid, m_if.data, m_if.last, s_if.ready);
                    end
                    n_vec++;
                    if (filt_in3 !== 10'sd10 || filt_in4 !== 10'sd20 || filt_in6 !== 10'sd40 || busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL stall_taps: in3=%0d in4=%0d in6=%0d busy=%b, want 10 20 40 1",
                                 filt_in3, filt_in4, filt_in6, busy);
                    end
                end
                @(posedge clk);
                #2;
                m_if.ready = 1'b1;
            end
        join
        wait_beats(exp_q.size(), "stall");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL stall_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                         i, rx_q[i][DW], rx_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
    endtask

    task automatic test_reset_mid_line();
        tx_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        rx_q.delete();
        fork
            drive_line(1'b0, 0);
            begin
                int guard = 0;
                do begin
                    @(posedge clk);
                    #2;
                    guard++;
                end while (!m_if.valid && guard < 200);
                n_vec++;
                if (m_if.valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL midrst_emit: m_valid=%b want 1 before reset", m_if.valid);
                end
                rst_n = 1'b0;
                #1;
                n_vec++;
                if ({m_if.valid, m_if.last, s_if.ready, busy, m_if.data, taps_flat} !== '0) begin
                    n_err++;
                    $display("FAIL midrst_outputs: m_valid=%b m_last=%b s_ready=%b busy=%b m_data=%0d taps=%h, want all 0",
                             m_if.valid, m_if.last, s_if.ready, busy, m_if.data, taps_flat);
                end
            end
        join
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rx_q.delete();
        tx_q = '{8'd3, 8'd3, 8'd3};
        build_expected();
        drive_line(1'b1, 0);
        wait_beats(exp_q.size(), "midrst");
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midrst_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                         i, rx_q[i][DW], rx_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int l = 0; l < 8; l++) begin
            int n = $urandom_range(1, 12);
            tx_q.delete();
            rx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            build_expected();
            fork
                drive_line(1'b1, 2);
                begin
                    int guard = 0;
                    while (rx_q.size() < exp_q.size() && guard < 3000) begin
                        @(posedge clk);
                        #1;
                        m_if.ready = ($urandom_range(0, 3) != 0);
                        guard++;
                    end
                    @(posedge clk);
                    #1;
                    m_if.ready = 1'b1;
                end
            join
            wait_beats(exp_q.size(), "rand");
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                n_vec++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_line%0d_beat%0d: got last=%b data=%0d, want last=%b data=%0d",
                             l, i, rx_q[i][DW], rx_q[i][DW-1:0], exp_q[i][DW], exp_q[i][DW-1:0]);
                end
            end
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL rand_line%0d_idle: busy=%b want 0", l, busy);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b1;
        test_reset();
        test_flat_line();
        test_ramp();
        test_single();
        test_clip();
        test_backpressure();
        test_reset_mid_line();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
